// File: rtl/exe_stage_pkg.sv
// Shared operation/select codes, pipeline control levels and divider state
// encoding for the RV32IM execute stage.
package exe_stage_pkg;

    localparam logic [7:0] EXE_OP_NOP    = 8'h00;
    localparam logic [7:0] EXE_OP_ADD    = 8'h01;
    localparam logic [7:0] EXE_OP_SUB    = 8'h02;
    localparam logic [7:0] EXE_OP_SLL    = 8'h03;
    localparam logic [7:0] EXE_OP_SLT    = 8'h04;
    localparam logic [7:0] EXE_OP_SLTU   = 8'h05;
    localparam logic [7:0] EXE_OP_XOR    = 8'h06;
    localparam logic [7:0] EXE_OP_SRL    = 8'h07;
    localparam logic [7:0] EXE_OP_SRA    = 8'h08;
    localparam logic [7:0] EXE_OP_OR     = 8'h09;
    localparam logic [7:0] EXE_OP_AND    = 8'h0A;
    localparam logic [7:0] EXE_OP_LUI    = 8'h0B;
    localparam logic [7:0] EXE_OP_AUIPC  = 8'h0C;
    localparam logic [7:0] EXE_OP_JAL    = 8'h0D;
    localparam logic [7:0] EXE_OP_MUL    = 8'h10;
    localparam logic [7:0] EXE_OP_MULH   = 8'h11;
    localparam logic [7:0] EXE_OP_MULHSU = 8'h12;
    localparam logic [7:0] EXE_OP_MULHU  = 8'h13;
    localparam logic [7:0] EXE_OP_DIV    = 8'h14;
    localparam logic [7:0] EXE_OP_DIVU   = 8'h15;
    localparam logic [7:0] EXE_OP_REM    = 8'h16;
    localparam logic [7:0] EXE_OP_REMU   = 8'h17;
    localparam logic [7:0] EXE_OP_LB     = 8'h20;
    localparam logic [7:0] EXE_OP_LH     = 8'h21;
    localparam logic [7:0] EXE_OP_LW     = 8'h22;
    localparam logic [7:0] EXE_OP_LBU    = 8'h23;
    localparam logic [7:0] EXE_OP_LHU    = 8'h24;
    localparam logic [7:0] EXE_OP_SB     = 8'h28;
    localparam logic [7:0] EXE_OP_SH     = 8'h29;
    localparam logic [7:0] EXE_OP_SW     = 8'h2A;

    localparam logic [2:0] EXE_RES_NOP   = 3'd0;
    localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
    localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
    localparam logic [2:0] EXE_RES_ARITH = 3'd3;
    localparam logic [2:0] EXE_RES_MUL   = 3'd4;
    localparam logic [2:0] EXE_RES_DIV   = 3'd5;
    localparam logic [2:0] EXE_RES_JUMP  = 3'd6;
    localparam logic [2:0] EXE_RES_LDST  = 3'd7;

    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic        STOP         = 1'b1;
    localparam logic        NOSTOP       = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/exe_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign correction applied on the way out.
module exe_div
    import exe_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic            abort,
    input  logic            hold,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CNT_W = $clog2(XLEN);

    div_state_e       state, state_nxt;
    logic [XLEN-1:0]  quot_p0, rem_p0, dvs_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             neg_q_p0, neg_r_p0;
    logic             dvd_neg, dvs_neg, dvs_zero, last_iter;
    logic [XLEN-1:0]  dvd_abs, dvs_abs;
    logic [XLEN:0]    trial, diff;

    assign dvd_neg   = signed_op & dividend[XLEN-1];
    assign dvs_neg   = signed_op & divisor[XLEN-1];
    assign dvd_abs   = dvd_neg ? -dividend : dividend;
    assign dvs_abs   = dvs_neg ? -divisor : divisor;
    assign dvs_zero  = (divisor == '0);
    assign last_iter = (cnt_p0 == CNT_W'(XLEN - 1));

    // Partial remainder shifted left with the next dividend bit; a borrow
    // out of the top bit means the divisor does not fit this round.
    assign trial = {rem_p0, quot_p0[XLEN-1]};
    assign diff  = trial - {1'b0, dvs_p0};

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) state <= DIV_IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (!abort && start) state_nxt = dvs_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (abort) state_nxt = DIV_IDLE;
                      else if (last_iter) state_nxt = DIV_DONE;
            DIV_DONE: if (abort || hold == NOSTOP) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            quot_p0  <= '0;
            rem_p0   <= '0;
            dvs_p0   <= '0;
            cnt_p0   <= '0;
            neg_q_p0 <= 1'b0;
            neg_r_p0 <= 1'b0;
        end else if (state == DIV_IDLE && start && !abort) begin
            cnt_p0 <= '0;
            dvs_p0 <= dvs_abs;
            if (dvs_zero) begin
                quot_p0  <= '1;
                rem_p0   <= dividend;
                neg_q_p0 <= 1'b0;
                neg_r_p0 <= 1'b0;
            end else begin
                quot_p0  <= dvd_abs;
                rem_p0   <= '0;
                neg_q_p0 <= dvd_neg ^ dvs_neg;
                neg_r_p0 <= dvd_neg;
            end
        end else if (state == DIV_BUSY && !abort) begin
            cnt_p0 <= cnt_p0 + 1'b1;
            if (diff[XLEN]) begin
                rem_p0  <= trial[XLEN-1:0];
                quot_p0 <= {quot_p0[XLEN-2:0], 1'b0};
            end else begin
                rem_p0  <= diff[XLEN-1:0];
                quot_p0 <= {quot_p0[XLEN-2:0], 1'b1};
            end
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_q_p0 ? -quot_p0 : quot_p0;
    assign remainder = neg_r_p0 ? -rem_p0 : rem_p0;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU/shift/compare/multiply, load/store address
// generation, and an iterative divider that freezes the front of the pipeline.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [XLEN-1:0]     reg1_i,
    input  logic [XLEN-1:0]     reg2_i,
    input  logic [4:0]          wAddr_i,
    input  logic                wreg_i,
    input  logic [31:0]         inst_i,
    input  logic [5:0]          stall,
    input  logic                flush,
    output logic [4:0]          wAddr_o,
    output logic                wreg_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic [ALUOP_W-1:0]  aluop_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    output logic                stall_req
);
    logic                   in_rst, kill;
    logic                   op_valid, is_div, is_rem, div_signed, is_load, is_store;
    logic                   mul_a_sgn, mul_b_sgn, mul_lo;
    logic [XLEN-1:0]        logic_res, shift_res, arith_res, jump_res, mul_res, div_res, sel_res;
    logic [XLEN-1:0]        ld_off, st_off;
    logic [2*XLEN-1:0]      mul_a, mul_b, prod;
    logic signed [XLEN-1:0] reg1_s, reg2_s;
    logic [4:0]             shamt;
    logic                   div_start, div_busy, div_done;
    logic [XLEN-1:0]        div_quot, div_rem;
    logic                   unused_bits;

    assign reg1_s      = reg1_i;
    assign reg2_s      = reg2_i;
    assign shamt       = reg2_i[4:0];
    assign ld_off      = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign st_off      = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign unused_bits = ^{inst_i[19:12], inst_i[6:0], stall[5:4], stall[2:0]};

    always_comb begin
        op_valid   = 1'b1;
        is_div     = 1'b0;
        is_rem     = 1'b0;
        div_signed = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        mul_a_sgn  = 1'b0;
        mul_b_sgn  = 1'b0;
        mul_lo     = 1'b0;
        logic_res  = '0;
        shift_res  = '0;
        arith_res  = '0;
        jump_res   = '0;
        case (aluop_i)
            EXE_OP_AND:               logic_res = reg1_i & reg2_i;
            EXE_OP_OR:                logic_res = reg1_i | reg2_i;
            EXE_OP_XOR:               logic_res = reg1_i ^ reg2_i;
            EXE_OP_SLL:               shift_res = reg1_i << shamt;
            EXE_OP_SRL:               shift_res = reg1_i >> shamt;
            EXE_OP_SRA:               shift_res = reg1_s >>> shamt;
            EXE_OP_ADD, EXE_OP_AUIPC: arith_res = reg1_i + reg2_i;
            EXE_OP_SUB:               arith_res = reg1_i - reg2_i;
            EXE_OP_SLT:               arith_res = XLEN'(reg1_s < reg2_s);
            EXE_OP_SLTU:              arith_res = XLEN'(reg1_i < reg2_i);
            EXE_OP_LUI:               arith_res = reg2_i;
            EXE_OP_JAL:               jump_res  = reg1_i + XLEN'(4);
            EXE_OP_MUL:               mul_lo    = 1'b1;
            EXE_OP_MULH: begin
                mul_a_sgn = 1'b1;
                mul_b_sgn = 1'b1;
            end
            EXE_OP_MULHSU:            mul_a_sgn = 1'b1;
            EXE_OP_MULHU:             mul_lo    = 1'b0;
            EXE_OP_DIV: begin
                is_div     = 1'b1;
                div_signed = 1'b1;
            end
            EXE_OP_DIVU:              is_div    = 1'b1;
            EXE_OP_REM: begin
                is_div     = 1'b1;
                is_rem     = 1'b1;
                div_signed = 1'b1;
            end
            EXE_OP_REMU: begin
                is_div = 1'b1;
                is_rem = 1'b1;
            end
            EXE_OP_LB, EXE_OP_LH, EXE_OP_LW, EXE_OP_LBU, EXE_OP_LHU: is_load = 1'b1;
            EXE_OP_SB, EXE_OP_SH, EXE_OP_SW:                         is_store = 1'b1;
            default:                  op_valid  = 1'b0;
        endcase
    end

    // One 64x64 multiply mod 2^64 of sign- or zero-extended operands covers
    // every signedness combination of MUL/MULH/MULHSU/MULHU.
    assign mul_a   = {{XLEN{mul_a_sgn & reg1_i[XLEN-1]}}, reg1_i};
    assign mul_b   = {{XLEN{mul_b_sgn & reg2_i[XLEN-1]}}, reg2_i};
    assign prod    = mul_a * mul_b;
    assign mul_res = mul_lo ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign div_res = div_done ? (is_rem ? div_rem : div_quot) : ZERO_WORD;

    always_comb begin
        case (alusel_i)
            EXE_RES_LOGIC: sel_res = logic_res;
            EXE_RES_SHIFT: sel_res = shift_res;
            EXE_RES_ARITH: sel_res = arith_res;
            EXE_RES_MUL:   sel_res = mul_res;
            EXE_RES_DIV:   sel_res = div_res;
            EXE_RES_JUMP:  sel_res = jump_res;
            default:       sel_res = ZERO_WORD;
        endcase
    end

    assign div_start = is_div & ~div_busy & ~div_done & ~kill;

    exe_div #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .signed_op(div_signed),
        .abort    (flush),
        .hold     (stall[3] == STOP),
        .dividend (reg1_i),
        .divisor  (reg2_i),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot),
        .remainder(div_rem)
    );

    // Everything is forced to zero while reset is held, independent of the clock.
    assign in_rst      = (rst == RST_ENABLE);
    assign kill        = in_rst | flush;
    assign wreg_o      = ~kill & wreg_i & op_valid & (~is_div | div_done);
    assign wdata_o     = (kill || !op_valid) ? ZERO_WORD : sel_res;
    assign wAddr_o     = in_rst ? NOP_REG_ADDR : wAddr_i;
    assign aluop_o     = in_rst ? '0 : aluop_i;
    assign mem_addr_o  = in_rst   ? ZERO_WORD :
                         is_load  ? reg1_i + ld_off :
                         is_store ? reg1_i + st_off : ZERO_WORD;
    assign mem_wdata_o = (in_rst || !is_store) ? ZERO_WORD : reg2_i;
    assign stall_req   = ~kill & (div_start | div_busy);

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: single-cycle ops, address generation and the
// divider's latency, zero-divisor, overflow, hold, flush and reset behaviour.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i, inst_i;
    logic [4:0]  wAddr_i;
    logic        wreg_i;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wAddr_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [7:0]  aluop_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        stall_req;

    int n_chk = 0;
    int n_err = 0;

    exe_stage dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wAddr_i    (wAddr_i),
        .wreg_i     (wreg_i),
        .inst_i     (inst_i),
        .stall      (stall),
        .flush      (flush),
        .wAddr_o    (wAddr_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .aluop_o    (aluop_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] inst);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        inst_i   = inst;
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_cyc, input bit hold,
                           input string tag);
        int cyc;
        @(posedge clk);
        #1;
        stall = hold ? 6'b001000 : 6'b000000;
        drive(op, EXE_RES_DIV, a, b, 32'h0);
        cyc = 0;
        @(negedge clk);
        while (stall_req && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, cyc, exp_cyc);
        check({tag, "_result"}, wdata_o, exp);
        check({tag, "_wreg"}, wreg_o, 1);
    endtask

    initial begin
        rst     = 1'b0;
        flush   = 1'b0;
        stall   = 6'b0;
        wreg_i  = 1'b1;
        wAddr_i = 5'd7;
        drive(EXE_OP_ADD, EXE_RES_ARITH, 32'h1, 32'h2, 32'h0);

        // Reset holds every output at zero.
        @(negedge clk);
        check("rst_wdata", wdata_o, 0);
        check("rst_wreg", wreg_o, 0);
        check("rst_stall", stall_req, 0);
        check("rst_waddr", wAddr_o, 0);
        rst = 1'b1;

        drive(EXE_OP_ADD, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 32'h0);
        #1;
        check("add_ovf", wdata_o, 32'h8000_0000);
        check("add_stall", stall_req, 0);
        check("add_wreg", wreg_o, 1);
        check("add_waddr", wAddr_o, 7);
        check("add_memaddr", mem_addr_o, 0);

        drive(EXE_OP_SRA, EXE_RES_SHIFT, 32'h8000_0000, 32'h4, 32'h0);
        #1 check("sra", wdata_o, 32'hF800_0000);
        drive(EXE_OP_SRL, EXE_RES_SHIFT, 32'h8000_0000, 32'h24, 32'h0);
        #1 check("srl_shamt5", wdata_o, 32'h0800_0000);
        drive(EXE_OP_SLT, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 32'h0);
        #1 check("slt", wdata_o, 1);
        drive(EXE_OP_SLTU, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 32'h0);
        #1 check("sltu", wdata_o, 0);

        drive(EXE_OP_MULHU, EXE_RES_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        #1 check("mulhu", wdata_o, 32'hFFFF_FFFE);
        check("mulhu_stall", stall_req, 0);
        drive(EXE_OP_MULH, EXE_RES_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        #1 check("mulh", wdata_o, 32'h0000_0000);
        drive(EXE_OP_MULHSU, EXE_RES_MUL, 32'hFFFF_FFFF, 32'h2, 32'h0);
        #1 check("mulhsu", wdata_o, 32'hFFFF_FFFF);
        drive(EXE_OP_MUL, EXE_RES_MUL, 32'h3, 32'hFFFF_FFFE, 32'h0);
        #1 check("mul", wdata_o, 32'hFFFF_FFFA);

        drive(8'hFF, EXE_RES_ARITH, 32'h5, 32'h6, 32'h0);
        #1 check("inv_wreg", wreg_o, 0);
        check("inv_wdata", wdata_o, 0);

        drive(EXE_OP_LW, EXE_RES_LDST, 32'h0000_1000, 32'h0, 32'hFFC0_2003);
        #1 check("lw_addr", mem_addr_o, 32'h0000_0FFC);
        check("lw_wdata", mem_wdata_o, 0);
        drive(EXE_OP_SW, EXE_RES_LDST, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_2423);
        #1 check("sw_addr", mem_addr_o, 32'h0000_1008);
        check("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("sw_aluop", aluop_o, EXE_OP_SW);

        run_div(EXE_OP_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 1'b0, "div_m7_2");
        run_div(EXE_OP_REM,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, 1'b0, "rem_m7_2");
        run_div(EXE_OP_DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF, 1, 1'b0, "divu_by0");
        run_div(EXE_OP_REMU, 32'h5, 32'h0, 32'h0000_0005, 1, 1'b0, "remu_by0");
        run_div(EXE_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0, "div_ovf");
        run_div(EXE_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33, 1'b0, "rem_ovf");
        run_div(EXE_OP_REM,  32'h7, 32'hFFFF_FFFE, 32'h1, 33, 1'b0, "rem_7_m2");

        // Result must stay put while the EXE/MEM register is held.
        run_div(EXE_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1, "divu_hold");
        repeat (3) begin
            @(negedge clk);
            check("hold_result", wdata_o, 32'd14);
            check("hold_stall", stall_req, 0);
        end
        stall = 6'b0;
        @(negedge clk);
        check("hold_exit_restart", stall_req, 1);
        flush = 1'b1;
        #1 check("hold_flush_stall", stall_req, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(EXE_OP_NOP, EXE_RES_NOP, 32'h0, 32'h0, 32'h0);

        // Flush in the middle of the iterations.
        @(posedge clk);
        #1 drive(EXE_OP_DIV, EXE_RES_DIV, 32'd1000, 32'd3, 32'h0);
        repeat (11) @(negedge clk);
        check("flush_pre_stall", stall_req, 1);
        flush = 1'b1;
        #1 check("flush_stall", stall_req, 0);
        check("flush_wreg", wreg_o, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(EXE_OP_ADD, EXE_RES_ARITH, 32'd5, 32'd6, 32'h0);
        @(negedge clk);
        check("post_flush_stall", stall_req, 0);
        check("post_flush_add", wdata_o, 32'd11);

        // Reset in the middle of a divide.
        @(posedge clk);
        #1 drive(EXE_OP_DIVU, EXE_RES_DIV, 32'd1000, 32'd3, 32'h0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_stall", stall_req, 0);
        check("midrst_wreg", wreg_o, 0);
        check("midrst_wdata", wdata_o, 0);
        check("midrst_aluop", aluop_o, 0);
        drive(EXE_OP_ADD, EXE_RES_ARITH, 32'd2, 32'd3, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_stall", stall_req, 0);
        check("post_rst_add", wdata_o, 32'd5);

        run_div(EXE_OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 1'b0, "divu_big");
        run_div(EXE_OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0, "remu_100_7");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
